efb_wb_arbiter: RTL and testbench

- Arbitrates the single EFB Wishbone slave port between two masters.
- Requester 0 is spi_controller, the ADC readout path, and has high priority.
- Requester 1 is storage_interface, the SD-card path on spi_csn.
- Keeps multi-cycle SPI transfers atomic via a per-master lock, prevents starvation of requester 1, and recovers from a hung EFB with an ack timeout.
- Sits between the masters and efb_inst, on clock_84_0000.

---
 rtl/efb_wb_arbiter_if.sv | 62 ++++++
 rtl/efb_wb_arbiter.sv | 181 ++++++++++++++++++
 tb/tb_efb_wb_arbiter.sv | 255 +++++++++++++++++++++++++
 3 files changed

// File: rtl/efb_wb_arbiter_if.sv
`default_nettype none
// ============================================================================
//  Module   : efb_wb_arbiter_if
//  Purpose  : Wishbone signal bundle between the two EFB masters, the
//             arbiter and the single EFB slave port.
//  Modports : slave  - arbiter view (takes m0_*/m1_* requests, drives s_*)
//             master - environment view (masters and EFB side)
//  Signals  : m{0,1}_cyc/stb/we/lock/adr/dat_o  requests from the masters
//             m{0,1}_dat_i/ack                  responses to the masters
//             s_cyc/stb/we/adr/dat_o            forwarded cycle to the EFB
//             s_dat_i/ack                       EFB response
//  Revision : 1.0  initial release
// ============================================================================
interface efb_wb_arbiter_if #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 8
);
  logic              m0_cyc;
  logic              m0_stb;
  logic              m0_we;
  logic              m0_lock;
  logic [ADDR_W-1:0] m0_adr;
  logic [DATA_W-1:0] m0_dat_o;
  logic [DATA_W-1:0] m0_dat_i;
  logic              m0_ack;

  logic              m1_cyc;
  logic              m1_stb;
  logic              m1_we;
  logic              m1_lock;
  logic [ADDR_W-1:0] m1_adr;
  logic [DATA_W-1:0] m1_dat_o;
  logic [DATA_W-1:0] m1_dat_i;
  logic              m1_ack;

  logic              s_cyc;
  logic              s_stb;
  logic              s_we;
  logic [ADDR_W-1:0] s_adr;
  logic [DATA_W-1:0] s_dat_o;
  logic [DATA_W-1:0] s_dat_i;
  logic              s_ack;

  modport slave (
    input  m0_cyc, m0_stb, m0_we, m0_lock, m0_adr, m0_dat_o,
    output m0_dat_i, m0_ack,
    input  m1_cyc, m1_stb, m1_we, m1_lock, m1_adr, m1_dat_o,
    output m1_dat_i, m1_ack,
    output s_cyc, s_stb, s_we, s_adr, s_dat_o,
    input  s_dat_i, s_ack
  );

  modport master (
    output m0_cyc, m0_stb, m0_we, m0_lock, m0_adr, m0_dat_o,
    input  m0_dat_i, m0_ack,
    output m1_cyc, m1_stb, m1_we, m1_lock, m1_adr, m1_dat_o,
    input  m1_dat_i, m1_ack,
    input  s_cyc, s_stb, s_we, s_adr, s_dat_o,
    output s_dat_i, s_ack
  );
endinterface
`default_nettype wire

// File: rtl/efb_wb_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : efb_wb_arbiter
//  Purpose  : Shares the EFB Wishbone slave port between the ADC readout
//             master (m0, high priority) and the SD-card master (m1).
//             Per-master lock keeps multi-byte SPI transfers atomic, a
//             starvation counter forces m1 in after STARVE_LIMIT contended
//             m0 grants, and an ack timeout recovers from a hung EFB.
//  Ports    : clock       system clock (clock_84_0000)
//             reset       asynchronous active-low reset
//             bus         efb_wb_arbiter_if.slave (masters + EFB signals)
//             grant       one-hot owner, 01 = m0, 10 = m1, 00 = none
//             timeout_err one-cycle pulse when an ack timeout fires
//  Revision : 1.0  initial release
// ============================================================================
module efb_wb_arbiter #(
  parameter int ADDR_W         = 8,
  parameter int DATA_W         = 8,
  parameter int STARVE_LIMIT   = 4,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                  clock,
  input  logic                  reset,
  efb_wb_arbiter_if.slave       bus,
  output logic [1:0]            grant,
  output logic                  timeout_err
);

  localparam int c_starve_w = $clog2(STARVE_LIMIT + 1);
  localparam int c_tmo_w    = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [c_starve_w-1:0] c_starve_max = c_starve_w'(STARVE_LIMIT);
  localparam logic [c_tmo_w-1:0]    c_tmo_last   = c_tmo_w'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    OWN0    = 2'd1,
    OWN1    = 2'd2,
    RELEASE = 2'd3
  } state_t;

  state_t                r_state;
  state_t                w_state_nxt;
  logic [1:0]            r_grant;
  logic [1:0]            w_grant_nxt;
  logic [c_starve_w-1:0] r_starve_cnt;
  logic [c_starve_w-1:0] w_starve_nxt;
  logic [c_tmo_w-1:0]    r_tmo_cnt;
  logic [c_tmo_w-1:0]    w_tmo_nxt;

  logic w_own0;
  logic w_own1;
  logic w_owner_stb;
  logic w_tmo_hit;

  assign w_own0 = (r_state == OWN0);
  assign w_own1 = (r_state == OWN1);

  // Strobe of the current owner before any timeout masking; this is what
  // the timeout counter watches.
  assign w_owner_stb = (w_own0 & bus.m0_stb) | (w_own1 & bus.m1_stb);

  // A real ack on the last allowed cycle wins over the timeout.
  assign w_tmo_hit = w_owner_stb & ~bus.s_ack & (r_tmo_cnt == c_tmo_last);

  // --------------------------------------------------------------------------
  // State register
  // --------------------------------------------------------------------------
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_state      <= IDLE;
      r_grant      <= 2'b00;
      r_starve_cnt <= '0;
      r_tmo_cnt    <= '0;
    end else begin
      r_state      <= w_state_nxt;
      r_grant      <= w_grant_nxt;
      r_starve_cnt <= w_starve_nxt;
      r_tmo_cnt    <= w_tmo_nxt;
    end
  end

  // --------------------------------------------------------------------------
  // Next-state, grant, starvation and timeout counters
  // --------------------------------------------------------------------------
  always_comb begin
    w_state_nxt  = r_state;
    w_grant_nxt  = r_grant;
    w_starve_nxt = r_starve_cnt;

    unique case (r_state)
      IDLE: begin
        if (bus.m1_cyc && (!bus.m0_cyc || (r_starve_cnt == c_starve_max))) begin
          w_state_nxt  = OWN1;
          w_grant_nxt  = 2'b10;
          w_starve_nxt = '0;
        end else if (bus.m0_cyc) begin
          w_state_nxt = OWN0;
          w_grant_nxt = 2'b01;
          // Only grants that made m1 wait count towards starvation.
          if (!bus.m1_cyc) begin
            w_starve_nxt = '0;
          end else if (r_starve_cnt != c_starve_max) begin
            w_starve_nxt = r_starve_cnt + c_starve_w'(1);
          end
        end
      end
      OWN0: begin
        // Timeout releases the bus even if the master holds its lock.
        if (w_tmo_hit || (!bus.m0_cyc && !bus.m0_lock)) begin
          w_state_nxt = RELEASE;
          w_grant_nxt = 2'b00;
        end
      end
      OWN1: begin
        if (w_tmo_hit || (!bus.m1_cyc && !bus.m1_lock)) begin
          w_state_nxt = RELEASE;
          w_grant_nxt = 2'b00;
        end
      end
      RELEASE: begin
        // One dead cycle so the EFB always sees s_cyc fall between owners.
        w_state_nxt = IDLE;
        w_grant_nxt = 2'b00;
      end
      default: begin
        w_state_nxt = IDLE;
        w_grant_nxt = 2'b00;
      end
    endcase

    if (w_state_nxt != r_state) begin
      w_tmo_nxt = '0;
    end else if (w_owner_stb && !bus.s_ack) begin
      w_tmo_nxt = r_tmo_cnt + c_tmo_w'(1);
    end else begin
      w_tmo_nxt = '0;
    end
  end

  // --------------------------------------------------------------------------
  // Bus multiplexing (combinational pass-through from the owner)
  // --------------------------------------------------------------------------
  always_comb begin
    bus.s_cyc    = 1'b0;
    bus.s_stb    = 1'b0;
    bus.s_we     = 1'b0;
    bus.s_adr    = '0;
    bus.s_dat_o  = '0;
    bus.m0_ack   = 1'b0;
    bus.m1_ack   = 1'b0;
    bus.m0_dat_i = bus.s_dat_i;
    bus.m1_dat_i = bus.s_dat_i;
    timeout_err  = w_tmo_hit;

    if (w_own0) begin
      bus.s_cyc   = bus.m0_cyc & ~w_tmo_hit;
      bus.s_stb   = bus.m0_stb & ~w_tmo_hit;
      bus.s_we    = bus.m0_we;
      bus.s_adr   = bus.m0_adr;
      bus.s_dat_o = bus.m0_dat_o;
      bus.m0_ack  = bus.s_ack | w_tmo_hit;
      if (w_tmo_hit) begin
        bus.m0_dat_i = '1;
      end
    end else if (w_own1) begin
      bus.s_cyc   = bus.m1_cyc & ~w_tmo_hit;
      bus.s_stb   = bus.m1_stb & ~w_tmo_hit;
      bus.s_we    = bus.m1_we;
      bus.s_adr   = bus.m1_adr;
      bus.s_dat_o = bus.m1_dat_o;
      bus.m1_ack  = bus.s_ack | w_tmo_hit;
      if (w_tmo_hit) begin
        bus.m1_dat_i = '1;
      end
    end
  end

  assign grant = r_grant;

endmodule
`default_nettype wire

// File: tb/tb_efb_wb_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : tb_efb_wb_arbiter
//  Purpose  : Directed, table-driven bench for efb_wb_arbiter. Each table
//             row gives the master/EFB inputs for one cycle and the outputs
//             expected in that cycle; timeout and reset sequences are
//             written out by hand.
//  Revision : 1.0  initial release
// ============================================================================
module tb_efb_wb_arbiter;

  logic       clock = 1'b0;
  logic       reset = 1'b0;
  logic [1:0] grant;
  logic       timeout_err;

  efb_wb_arbiter_if #(.ADDR_W(8), .DATA_W(8)) bus ();

  efb_wb_arbiter #(
    .ADDR_W        (8),
    .DATA_W        (8),
    .STARVE_LIMIT  (4),
    .TIMEOUT_CYCLES(255)
  ) u_dut (
    .clock      (clock),
    .reset      (reset),
    .bus        (bus),
    .grant      (grant),
    .timeout_err(timeout_err)
  );

  always #5 clock = ~clock;

  // Input bit order: {m0c, m0s, m0w, m0l, m1c, m1s, m1w, m1l, s_ack}
  localparam logic [8:0] c_m0w   = 9'b111000000;
  localparam logic [8:0] c_m0r   = 9'b110000000;
  localparam logic [8:0] c_m0rl  = 9'b110100000;
  localparam logic [8:0] c_m1w   = 9'b000011100;
  localparam logic [8:0] c_m1l   = 9'b000011110;
  localparam logic [8:0] c_m1gap = 9'b000000010;
  localparam logic [8:0] c_ack   = 9'b000000001;
  localparam logic [8:0] c_none  = 9'b000000000;
  localparam logic [23:0] c_e0   = 24'h0;

  // Expected bit order: {grant[1:0], s_cyc, s_stb, s_we, s_adr[7:0],
  //                      s_dat_o[7:0], m0_ack, m1_ack, timeout_err}
  typedef struct {
    logic [8:0]  in;
    logic [23:0] exp;
  } vec_t;

  vec_t tbl[$];
  int   total = 0;
  int   bad   = 0;

  function automatic logic [23:0] own(input logic [1:0] g, input logic c,
                                      input logic s, input logic w,
                                      input logic a);
    logic [7:0] adr;
    logic [7:0] dat;
    adr = (g == 2'b01) ? 8'h59 : 8'h3C;
    dat = (g == 2'b01) ? 8'hA5 : 8'h5A;
    return {g, c, s, w, adr, dat, g[0] & a, g[1] & a, 1'b0};
  endfunction

  task automatic add(input logic [8:0] i, input logic [23:0] e);
    vec_t v;
    v.in  = i;
    v.exp = e;
    tbl.push_back(v);
  endtask

  task automatic drive(input logic [8:0] i);
    {bus.m0_cyc, bus.m0_stb, bus.m0_we, bus.m0_lock,
     bus.m1_cyc, bus.m1_stb, bus.m1_we, bus.m1_lock, bus.s_ack} = i;
  endtask

  task automatic chk(input string nm, input logic [63:0] got,
                     input logic [63:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s: got=%h want=%h", nm, got, want);
    end
  endtask

  // Timeout sequence: m0 locked read with no ack for 255 strobe cycles.
  // ack_last=1 puts a real ack on the 255th cycle instead.
  task automatic tmo_run(input bit ack_last);
    int errs;
    errs = 0;
    drive(c_m0rl);
    #1 chk("tmo_idle", grant, 2'b00);
    @(negedge clock);
    for (int k = 1; k <= 254; k++) begin
      drive(c_m0rl);
      #1;
      if (grant !== 2'b01 || bus.s_cyc !== 1'b1 || bus.s_stb !== 1'b1 ||
          bus.m0_ack !== 1'b0 || timeout_err !== 1'b0)
        errs++;
      @(negedge clock);
    end
    chk("tmo_wait", errs, 0);
    drive(c_m0rl | (ack_last ? c_ack : c_none));
    #1;
    if (!ack_last)
      chk("tmo_fire", {bus.m0_ack, bus.m0_dat_i, timeout_err, bus.s_cyc,
                       bus.s_stb, bus.m1_ack},
          {1'b1, 8'hFF, 1'b1, 1'b0, 1'b0, 1'b0});
    else
      chk("tmo_ack_wins", {bus.m0_ack, bus.m0_dat_i, timeout_err, bus.s_cyc,
                           bus.s_stb, bus.m1_ack},
          {1'b1, 8'hC3, 1'b0, 1'b1, 1'b1, 1'b0});
    @(negedge clock);
    if (!ack_last) begin
      // Lock still asserted, grant must be gone anyway.
      drive(c_m0rl);
      #1 chk("tmo_release", {grant, timeout_err, bus.s_cyc, bus.m0_ack},
             {2'b00, 1'b0, 1'b0, 1'b0});
      @(negedge clock);
      drive(c_none);
      #1 chk("tmo_idle_after", grant, 2'b00);
      @(negedge clock);
    end else begin
      drive(c_none);
      #1 chk("ack_still_own", {grant, timeout_err}, {2'b01, 1'b0});
      @(negedge clock);
      drive(c_none);
      #1 chk("ack_release", grant, 2'b00);
      @(negedge clock);
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got=timeout want=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    bus.m0_adr   = 8'h59;
    bus.m0_dat_o = 8'hA5;
    bus.m1_adr   = 8'h3C;
    bus.m1_dat_o = 8'h5A;
    bus.s_dat_i  = 8'hC3;
    drive(c_m0w | c_ack);

    // ---------------- table: single write and contention ----------------
    add(c_m0w, c_e0);
    add(c_m0w, own(2'b01, 1, 1, 1, 0));
    add(c_m0w, own(2'b01, 1, 1, 1, 0));
    add(c_m0w | c_ack, own(2'b01, 1, 1, 1, 1));
    add(c_none, own(2'b01, 0, 0, 0, 0));
    add(c_none, c_e0);
    add(c_none, c_e0);
    add(c_m0r | c_m1w, c_e0);
    add(c_m0r | c_m1w | c_ack, own(2'b01, 1, 1, 0, 1));
    add(c_m1w, own(2'b01, 0, 0, 0, 0));
    add(c_m1w, c_e0);
    add(c_m1w, c_e0);
    add(c_m1w | c_ack, own(2'b10, 1, 1, 1, 1));
    add(c_none, own(2'b10, 0, 0, 0, 0));
    add(c_none, c_e0);
    // ---------------- starvation: 4 m0 grants then m1 --------------------
    for (int t = 0; t < 4; t++) begin
      add(c_m0w | c_m1w, c_e0);
      add(c_m0w | c_m1w | c_ack, own(2'b01, 1, 1, 1, 1));
      add(c_m1w, own(2'b01, 0, 0, 0, 0));
      add(c_m1w, c_e0);
    end
    add(c_m0w | c_m1w, c_e0);
    add(c_m0w | c_m1w | c_ack, own(2'b10, 1, 1, 1, 1));
    add(c_m0w, own(2'b10, 0, 0, 0, 0));
    add(c_m0w, c_e0);
    add(c_m0w, c_e0);
    add(c_m0w | c_ack, own(2'b01, 1, 1, 1, 1));
    add(c_none, own(2'b01, 0, 0, 0, 0));
    add(c_none, c_e0);
    // Counter must be cleared: contention goes to m0 again.
    add(c_m0w | c_m1w, c_e0);
    add(c_m0w | c_m1w | c_ack, own(2'b01, 1, 1, 1, 1));
    add(c_m1w, own(2'b01, 0, 0, 0, 0));
    add(c_m1w, c_e0);
    add(c_m1w, c_e0);
    add(c_m1w | c_ack, own(2'b10, 1, 1, 1, 1));
    add(c_none, own(2'b10, 0, 0, 0, 0));
    add(c_none, c_e0);
    // ---------------- m1 lock across 3 transfers with gaps ---------------
    add(c_m1l, c_e0);
    add(c_m1l | c_m0w | c_ack, own(2'b10, 1, 1, 1, 1));
    for (int g = 0; g < 2; g++) begin
      add(c_m1gap | c_m0w, own(2'b10, 0, 0, 0, 0));
      add(c_m1gap | c_m0w, own(2'b10, 0, 0, 0, 0));
      add(c_m1l | c_m0w | c_ack, own(2'b10, 1, 1, 1, 1));
    end
    add(c_m0w, own(2'b10, 0, 0, 0, 0));
    add(c_m0w, c_e0);
    add(c_m0w, c_e0);
    add(c_m0w | c_ack, own(2'b01, 1, 1, 1, 1));
    add(c_none, own(2'b01, 0, 0, 0, 0));
    add(c_none, c_e0);

    // ---------------- reset state (inputs active during reset) -----------
    #2;
    chk("reset_state", {grant, bus.s_cyc, bus.s_stb, bus.s_we, bus.m0_ack,
                        bus.m1_ack, timeout_err, bus.s_adr},
        {2'b00, 6'b0, 8'h00});
    @(negedge clock);
    @(negedge clock);
    reset = 1'b1;

    foreach (tbl[i]) begin
      drive(tbl[i].in);
      #1;
      chk($sformatf("vec%0d", i),
          {grant, bus.s_cyc, bus.s_stb, bus.s_we, bus.s_adr, bus.s_dat_o,
           bus.m0_ack, bus.m1_ack, timeout_err, bus.m0_dat_i, bus.m1_dat_i},
          {tbl[i].exp, 8'hC3, 8'hC3});
      @(negedge clock);
    end

    // ---------------- ack timeout and ack-on-last-cycle ------------------
    tmo_run(1'b0);
    tmo_run(1'b1);

    // ---------------- asynchronous reset while m1 owns -------------------
    drive(c_m1w);
    #1 chk("rst_pre_idle", grant, 2'b00);
    @(negedge clock);
    drive(c_m1w);
    #1 chk("rst_own1", {grant, bus.s_cyc, bus.s_stb}, {2'b10, 1'b1, 1'b1});
    #1 bus.s_ack = 1'b1;
    #1 reset = 1'b0;
    #1 chk("rst_async", {grant, bus.s_cyc, bus.s_stb, bus.m1_ack, bus.m0_ack},
           {2'b00, 4'b0000});
    @(negedge clock);
    drive(c_none);
    @(negedge clock);
    reset = 1'b1;
    drive(c_m0w);
    #1 chk("post_rst_idle", grant, 2'b00);
    @(negedge clock);
    drive(c_m0w | c_ack);
    #1 chk("post_rst_own0", {grant, bus.s_cyc, bus.s_adr, bus.m0_ack},
           {2'b01, 1'b1, 8'h59, 1'b1});
    @(negedge clock);
    drive(c_none);
    @(negedge clock);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
